ahb_slave_if: RTL

- AHB-side front end of the AHB-to-APB bridge. Sits directly downstream of AHB_Master and consumes its Haddr/Htrans/Hwrite/Hwdata/Hreadyin.
- Pipelines address, data and direction into two register stages for the APB controller FSM.
- Decodes the three peripheral regions and produces valid and tempselx.
- Drives Hreadyout, Hresp and Hrdata back to the master, including the two-cycle AHB ERROR response for unmapped addresses.

---
 rtl/ahb_slave_if.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ahb_slave_if.sv
// ahb_slave_if: AHB-side front end of the AHB-to-APB bridge.
//
// It decodes the AHB address into one of NUM_SLV APB regions (tempselx)
// and flags accepted transfers to mapped regions (valid). It pipelines
// the address, write data and direction through two register stages for
// the APB controller. It also returns Hreadyout, Hresp and Hrdata to the
// master.
//
// Ports:
//   Hclk, Hresetn        clock, asynchronous active-low reset
//   Htrans, Hwrite,      AHB address-phase controls
//   Hreadyin, Haddr
//   Hwdata               AHB data-phase write data
//   Prdata               read data from the APB controller
//   bridge_ready         APB controller ready (0 = insert wait states)
//   valid, tempselx      accepted mapped transfer / one-hot region select
//   Haddr1/2, Hwdata1/2, two-stage pipelines (advance only on Hreadyin)
//   Hwrite_reg/_reg1
//   Hreadyout, Hresp,    response to the master
//   Hrdata
//
// Build option: define AHB_DECODE_ERR_EN to give unmapped accepted
// transfers the two-cycle AHB ERROR response. When it is undefined,
// unmapped transfers complete as OKAY.
module ahb_slave_if #(
   parameter int unsigned       ADDR_W      = 32,
   parameter int unsigned       DATA_W      = 32,
   parameter int unsigned       NUM_SLV     = 3,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
   parameter logic [ADDR_W-1:0] REGION_SIZE = 32'h0400_0000
) (
   input  logic               Hclk,
   input  logic               Hresetn,
   input  logic [1:0]         Htrans,
   input  logic               Hwrite,
   input  logic               Hreadyin,
   input  logic [ADDR_W-1:0]  Haddr,
   input  logic [DATA_W-1:0]  Hwdata,
   input  logic [DATA_W-1:0]  Prdata,
   input  logic               bridge_ready,
   output logic               valid,
   output logic [NUM_SLV-1:0] tempselx,
   output logic [ADDR_W-1:0]  Haddr1,
   output logic [ADDR_W-1:0]  Haddr2,
   output logic [DATA_W-1:0]  Hwdata1,
   output logic [DATA_W-1:0]  Hwdata2,
   output logic               Hwrite_reg,
   output logic               Hwrite_reg1,
   output logic               Hreadyout,
   output logic [1:0]         Hresp,
   output logic [DATA_W-1:0]  Hrdata
);

   // Region bounds are computed one bit wider so the top region cannot wrap.
   localparam logic [ADDR_W:0] BASE_EXT = {1'b0, BASE_ADDR};
   localparam logic [ADDR_W:0] SIZE_EXT = {1'b0, REGION_SIZE};

   logic [NUM_SLV-1:0] sel;
   logic               hit;
   logic               in_okay;

   // Address / data / direction pipelines.
   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         Haddr1      <= '0;
         Haddr2      <= '0;
         Hwdata1     <= '0;
         Hwdata2     <= '0;
         Hwrite_reg  <= 1'b0;
         Hwrite_reg1 <= 1'b0;
      end else if (Hreadyin) begin
         Haddr1      <= Haddr;
         Haddr2      <= Haddr1;
         Hwdata1     <= Hwdata;
         Hwdata2     <= Hwdata1;
         Hwrite_reg  <= Hwrite;
         Hwrite_reg1 <= Hwrite_reg;
      end
   end

   // Region decode.
   always_comb begin
      logic [ADDR_W:0] addr_ext;
      logic [ADDR_W:0] lo;
      logic [ADDR_W:0] hi;
      sel      = '0;
      addr_ext = {1'b0, Haddr};
      lo       = '0;
      hi       = '0;
      for (int unsigned i = 0; i < NUM_SLV; i++) begin
         lo = BASE_EXT + (ADDR_W+1)'(i) * SIZE_EXT;
         hi = lo + SIZE_EXT;
         if (addr_ext >= lo && addr_ext < hi)
            sel[i] = 1'b1;
      end
   end

   assign hit = |sel;

`ifdef AHB_DECODE_ERR_EN
   typedef enum logic [1:0] {OKAY, ERR1, ERR2} err_state_t;

   err_state_t state;
   logic       resp_err;   // high in ERR1 and ERR2
   logic       hold_wait;  // high in ERR1 only

   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         state     <= OKAY;
         resp_err  <= 1'b0;
         hold_wait <= 1'b0;
      end else begin
         case (state)
            OKAY: begin
               if (Hreadyin && Htrans[1] && !hit) begin
                  state     <= ERR1;
                  resp_err  <= 1'b1;
                  hold_wait <= 1'b1;
               end
            end
            ERR1: begin
               state     <= ERR2;
               hold_wait <= 1'b0;
            end
            ERR2: begin
               state    <= OKAY;
               resp_err <= 1'b0;
            end
            default: begin
               state     <= OKAY;
               resp_err  <= 1'b0;
               hold_wait <= 1'b0;
            end
         endcase
      end
   end

   assign in_okay   = (state == OKAY);
   assign Hresp     = {1'b0, resp_err};
   assign Hreadyout = ~Hresetn | (in_okay ? bridge_ready : ~hold_wait);
`else
   assign in_okay   = 1'b1;
   assign Hresp     = 2'b00;
   assign Hreadyout = ~Hresetn | bridge_ready;
`endif

   // Decode outputs are gated by reset so that they read as zero
   // immediately while reset is held, even with live bus inputs.
   assign tempselx = Hresetn ? sel : '0;
   assign valid    = Hresetn & Hreadyin & Htrans[1] & hit & in_okay;
   assign Hrdata   = (Hresetn && in_okay) ? Prdata : '0;

endmodule
